// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencing controller: FSM state encoding,
// default parameter values and the step-counter width.
package lfsr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int W_DEF        = 8;
  localparam int LOAD_CYC_DEF = 2;
  localparam int TIMEOUT_DEF  = 1023;
  localparam int STEP_W       = 16;

  // Saturating increment: the step count sticks at all-ones rather than wrapping.
  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (v == {STEP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lfsr_period_counter.sv
// Step counter plus seed-recurrence compare. Counts generator steps since the
// last accepted start and flags the cycle where the generator output has come
// back round to the seed after at least one step.
module lfsr_period_counter
  import lfsr_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [W-1:0]      seed,
  input  logic [W-1:0]      lfsr,
  output logic [STEP_W-1:0] step,
  output logic [STEP_W-1:0] step_nxt,
  output logic              match
);

  assign step_nxt = sat_inc(step);
  assign match    = (step != '0) && (lfsr == seed);

  // Step counter: cleared on each accepted start, advances on every enabled step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (clr) begin
      step <= '0;
    end else if (inc) begin
      step <= step_nxt;
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// LFSR sequencing controller. Loads a seed into an external generator, steps it
// for a burst (or indefinitely), and reports completion.
// Optional feature macro: LFSR_CTRL_PERIOD_CHECK_EN -- adds seed-recurrence
// detection (period measurement, maximal-period flag, search timeout). Without
// it the period/status outputs are tied low and a zero burst runs until stop.
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int LOAD_CYC = LOAD_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_pause,
  input  logic [W-1:0] i_seed,
  input  logic [15:0]  i_burst,
  input  logic [W-1:0] i_lfsr,
  output logic         o_gen_valid,
  output logic         o_gen_soft_reset,
  output logic [W-1:0] o_gen_seed,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err_seed_zero,
  output logic         o_timeout,
  output logic         o_period_ok,
  output logic [15:0]  o_period
);

  state_t              state;
  logic [15:0]         load_cnt;
  logic [W-1:0]        seed_q;
  logic [STEP_W-1:0]   burst_q;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_nxt;
  logic                start_acc;
  logic                burst_end;
  logic                per_end;

  assign start_acc   = (state == S_IDLE) && i_start && !i_stop && (i_seed != '0);
  // Step enable follows pause within the same cycle, so it is decoded from the
  // registered state rather than registered itself.
  assign o_gen_valid = (state == S_RUN) && !i_pause;
  assign o_gen_seed  = seed_q;
  assign burst_end   = o_gen_valid && (burst_q != '0) && (step_nxt == burst_q);

`ifdef LFSR_CTRL_PERIOD_CHECK_EN
  localparam logic [STEP_W-1:0] FULL_PERIOD = STEP_W'((64'd1 << W) - 64'd1);

  logic        match;
  logic        hit;
  logic        to_end;
  logic        found_q;
  logic        timeout_q;
  logic        period_ok_q;
  logic [15:0] period_q;

  lfsr_period_counter #(.W(W)) u_period_counter (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .clr      (start_acc),
    .inc      (o_gen_valid),
    .seed     (seed_q),
    .lfsr     (i_lfsr),
    .step     (step),
    .step_nxt (step_nxt),
    .match    (match)
  );

  // Only the first recurrence in a run is recorded.
  assign hit     = (state == S_RUN) && match && !found_q;
  assign to_end  = o_gen_valid && (burst_q == '0) && !hit && (step_nxt == STEP_W'(TIMEOUT));
  assign per_end = (burst_q == '0) && (hit || to_end);

  assign o_period    = period_q;
  assign o_period_ok = period_ok_q;
  assign o_timeout   = timeout_q;

  // Period/status latch: cleared on accepted start, then holds the first result
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      period_q    <= '0;
      period_ok_q <= 1'b0;
      timeout_q   <= 1'b0;
      found_q     <= 1'b0;
    end else if (start_acc) begin
      period_q    <= '0;
      period_ok_q <= 1'b0;
      timeout_q   <= 1'b0;
      found_q     <= 1'b0;
    end else if ((state == S_RUN) && !i_stop) begin
      if (hit) begin
        period_q    <= step;
        period_ok_q <= (step == FULL_PERIOD);
        found_q     <= 1'b1;
      end
      if (to_end) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic lfsr_unused;

  assign lfsr_unused = ^i_lfsr;
  assign step_nxt    = sat_inc(step);
  assign per_end     = 1'b0;
  assign o_period    = '0;
  assign o_period_ok = 1'b0;
  assign o_timeout   = 1'b0;

  // Step counter: cleared on accepted start, advances on every enabled step
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step <= '0;
    end else if (start_acc) begin
      step <= '0;
    end else if (o_gen_valid) begin
      step <= step_nxt;
    end
  end
`endif

  // Control FSM: sequences seed load, stepping and completion with registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      load_cnt         <= '0;
      seed_q           <= '0;
      burst_q          <= '0;
      o_gen_soft_reset <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_err_seed_zero  <= 1'b0;
    end else begin
      o_done          <= 1'b0;
      o_err_seed_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            if (i_seed == '0) begin
              o_err_seed_zero <= 1'b1;
            end else begin
              seed_q           <= i_seed;
              burst_q          <= i_burst;
              load_cnt         <= '0;
              o_gen_soft_reset <= 1'b1;
              o_busy           <= 1'b1;
              state            <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (i_stop) begin
            o_gen_soft_reset <= 1'b0;
            o_done           <= 1'b1;
            state            <= S_DONE;
          end else if (load_cnt == 16'(LOAD_CYC - 1)) begin
            o_gen_soft_reset <= 1'b0;
            state            <= S_RUN;
          end else begin
            load_cnt <= load_cnt + 16'd1;
          end
        end
        S_RUN: begin
          if (i_stop || burst_end || per_end) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Testbench for lfsr_ctrl with an 8-bit maximal-length generator model
// (x^8+x^6+x^5+x^4+1). Expected run results are queued when a sequence is
// started and popped when the controller reports done.
module tb_lfsr_ctrl;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_pause = 1'b0;
  logic [7:0]  i_seed = 8'h00;
  logic [15:0] i_burst = 16'h0000;
  logic [7:0]  i_lfsr;
  logic        o_gen_valid;
  logic        o_gen_soft_reset;
  logic [7:0]  o_gen_seed;
  logic        o_busy;
  logic        o_done;
  logic        o_err_seed_zero;
  logic        o_timeout;
  logic        o_period_ok;
  logic [15:0] o_period;

  logic [7:0]  gen_q = 8'h00;
  logic        stuck = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int scnt = 0, vcnt = 0, ecnt = 0, bcnt = 0, dcnt = 0;

  typedef struct packed {
    logic [15:0] period;
    logic        ok;
    logic        to;
  } exp_t;

  exp_t exp_q[$];

  lfsr_ctrl dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_start          (i_start),
    .i_stop           (i_stop),
    .i_pause          (i_pause),
    .i_seed           (i_seed),
    .i_burst          (i_burst),
    .i_lfsr           (i_lfsr),
    .o_gen_valid      (o_gen_valid),
    .o_gen_soft_reset (o_gen_soft_reset),
    .o_gen_seed       (o_gen_seed),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err_seed_zero  (o_err_seed_zero),
    .o_timeout        (o_timeout),
    .o_period_ok      (o_period_ok),
    .o_period         (o_period)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Number of steps until the sequence returns to s, or 0 if not within limit.
  function automatic int ref_period(input logic [7:0] s, input int limit);
    logic [7:0] q;
    q = s;
    for (int k = 1; k <= limit; k++) begin
      q = lfsr_next(q);
      if (q == s) return k;
    end
    return 0;
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] s, input int limit, input logic to);
    exp_t e;
    e.period = 16'(ref_period(s, limit));
    e.ok     = (e.period == 16'd255);
    e.to     = to;
    return e;
  endfunction

  // Generator model
  always @(posedge clk) begin
    if (o_gen_soft_reset) gen_q <= o_gen_seed;
    else if (o_gen_valid) gen_q <= lfsr_next(gen_q);
  end

  assign i_lfsr = stuck ? 8'h55 : gen_q;

  // Per-cycle activity counters, sampled mid-cycle
  always @(negedge clk) begin
    if (o_gen_soft_reset) scnt++;
    if (o_gen_valid)      vcnt++;
    if (o_err_seed_zero)  ecnt++;
    if (o_busy)           bcnt++;
    if (o_done)           dcnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] s, input logic [15:0] b);
    i_seed  = s;
    i_burst = b;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int n;
    n = 0;
    while (o_gen_soft_reset && n < 20) begin
      tick();
      n++;
    end
    ok = o_busy && !o_gen_soft_reset;
  endtask

  task automatic wait_done(input int max, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < max) begin
      tick();
      n++;
      if (o_done) seen = 1'b1;
    end
  endtask

  // Ends a zero-burst run with stop when no recurrence search can end it.
  task automatic stop_now(output bit seen);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    seen = o_done;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({o_busy, o_done, o_gen_soft_reset, o_gen_valid, o_err_seed_zero, o_timeout, o_period_ok} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000",
               {o_busy, o_done, o_gen_soft_reset, o_gen_valid, o_err_seed_zero, o_timeout, o_period_ok});
    else n_pass++;
    n_checks++;
    if ({o_gen_seed, o_period} !== 24'h0)
      $display("FAIL reset_seed_period: got seed %h period %0d want 0", o_gen_seed, o_period);
    else n_pass++;
    i_rst_n = 1'b1;
  endtask

  task automatic test_period();
    exp_t e;
    int s0, n;
    bit ok, seen;
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    exp_q.push_back(mk_exp(8'h1A, 1023, 1'b0));
`else
    exp_q.push_back(exp_t'(0));
`endif
    s0 = scnt;
    start(8'h1A, 16'd0);
    n_checks++;
    if (o_gen_seed !== 8'h1A || o_busy !== 1'b1)
      $display("FAIL period_capture: got seed %h busy %b want 1a 1", o_gen_seed, o_busy);
    else n_pass++;
    wait_run(ok);
    n_checks++;
    if (!ok || (scnt - s0) != 2)
      $display("FAIL period_load_cycles: got %0d run %b want 2 1", scnt - s0, ok);
    else n_pass++;
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    wait_done(2000, n, seen);
`else
    repeat (300) tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_period !== 16'd0)
      $display("FAIL period_unbounded: got busy %b period %0d want 1 0", o_busy, o_period);
    else n_pass++;
    stop_now(seen);
`endif
    e = exp_q.pop_front();
    n_checks++;
    if (!seen || o_period !== e.period || o_period_ok !== e.ok || o_timeout !== e.to)
      $display("FAIL period_result: got done %b period %0d ok %b to %b want 1 %0d %b %b",
               seen, o_period, o_period_ok, o_timeout, e.period, e.ok, e.to);
    else n_pass++;
    tick();
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL period_done_pulse: got done %b busy %b want 0 0", o_done, o_busy);
    else n_pass++;
    n_checks++;
    if (o_period !== e.period || o_period_ok !== e.ok)
      $display("FAIL period_hold: got %0d %b want %0d %b", o_period, o_period_ok, e.period, e.ok);
    else n_pass++;
  endtask

  task automatic test_seed_zero();
    int s0, e0, b0;
    s0 = scnt; e0 = ecnt; b0 = bcnt;
    start(8'h00, 16'd5);
    n_checks++;
    if (o_err_seed_zero !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL seed_zero_err: got err %b busy %b want 1 0", o_err_seed_zero, o_busy);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if ((ecnt - e0) != 1 || (scnt - s0) != 0 || (bcnt - b0) != 0)
      $display("FAIL seed_zero_counts: got err %0d soft %0d busy %0d want 1 0 0",
               ecnt - e0, scnt - s0, bcnt - b0);
    else n_pass++;
  endtask

  task automatic test_burst_pause();
    exp_t e;
    int n, v0;
    bit ok, seen;
    exp_q.push_back(mk_exp(8'h7F, 9, 1'b0));
    start(8'h7F, 16'd10);
    wait_run(ok);
    v0 = vcnt;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      i_pause = (n >= 4 && n < 7);
      tick();
      n++;
      if (o_done) seen = 1'b1;
    end
    i_pause = 1'b0;
    n_checks++;
    if (!ok || !seen || n != 13)
      $display("FAIL burst_done_latency: got %0d done %b want 13 1", n, seen);
    else n_pass++;
    n_checks++;
    if ((vcnt - v0) != 10)
      $display("FAIL burst_valid_count: got %0d want 10", vcnt - v0);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (o_period !== e.period || o_timeout !== e.to)
      $display("FAIL burst_result: got %0d %b want %0d %b", o_period, o_timeout, e.period, e.to);
    else n_pass++;
    tick();
  endtask

  task automatic test_stop();
    exp_t e;
    bit ok;
    exp_q.push_back(mk_exp(8'h1A, 39, 1'b0));
    start(8'h1A, 16'd0);
    wait_run(ok);
    repeat (40) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    n_checks++;
    if (!ok || o_gen_valid !== 1'b0 || o_gen_soft_reset !== 1'b0 || o_done !== 1'b1)
      $display("FAIL stop_response: got valid %b soft %b done %b want 0 0 1",
               o_gen_valid, o_gen_soft_reset, o_done);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (o_period !== e.period || o_period_ok !== e.ok)
      $display("FAIL stop_period: got %0d %b want %0d %b", o_period, o_period_ok, e.period, e.ok);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int n;
    bit ok, seen;
    start(8'h1A, 16'd0);
    wait_run(ok);
    repeat (100) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_busy, o_gen_valid, o_gen_soft_reset, o_done, o_gen_seed} !== 12'h0)
      $display("FAIL midrun_reset: got busy %b valid %b soft %b done %b seed %h want all 0",
               o_busy, o_gen_valid, o_gen_soft_reset, o_done, o_gen_seed);
    else n_pass++;
    tick();
    i_rst_n = 1'b1;
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    exp_q.push_back(mk_exp(8'h1A, 1023, 1'b0));
`else
    exp_q.push_back(exp_t'(0));
`endif
    start(8'h1A, 16'd0);
    n_checks++;
    if (o_gen_soft_reset !== 1'b1 || o_busy !== 1'b1)
      $display("FAIL first_start_after_reset: got soft %b busy %b want 1 1", o_gen_soft_reset, o_busy);
    else n_pass++;
    wait_run(ok);
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    wait_done(2000, n, seen);
`else
    repeat (300) tick();
    stop_now(seen);
`endif
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || !seen || o_period !== e.period || o_period_ok !== e.ok)
      $display("FAIL restart_result: got done %b period %0d ok %b want 1 %0d %b",
               seen, o_period, o_period_ok, e.period, e.ok);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    int n, v0;
    bit ok, seen;
    stuck = 1'b1;
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    e.period = 16'd0; e.ok = 1'b0; e.to = 1'b1;
`else
    e = exp_t'(0);
`endif
    exp_q.push_back(e);
    start(8'h1A, 16'd0);
    wait_run(ok);
    v0 = vcnt;
`ifdef LFSR_CTRL_PERIOD_CHECK_EN
    wait_done(1200, n, seen);
    n_checks++;
    if (!seen || (vcnt - v0) != 1023)
      $display("FAIL timeout_steps: got %0d done %b want 1023 1", vcnt - v0, seen);
    else n_pass++;
`else
    repeat (1100) tick();
    n_checks++;
    if (o_busy !== 1'b1 || (vcnt - v0) != 1100)
      $display("FAIL unbounded_steps: got busy %b steps %0d want 1 1100", o_busy, vcnt - v0);
    else n_pass++;
    stop_now(seen);
`endif
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || !seen || o_timeout !== e.to || o_period !== e.period)
      $display("FAIL timeout_result: got done %b to %b period %0d want 1 %b %0d",
               seen, o_timeout, o_period, e.to, e.period);
    else n_pass++;
    stuck = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n, v0;
    bit ok, seen;
    exp_q.push_back(mk_exp(8'h3C, 19, 1'b0));
    start(8'h3C, 16'd20);
    wait_run(ok);
    repeat (3) tick();
    start(8'h99, 16'd3);
    n_checks++;
    if (o_gen_seed !== 8'h3C || o_gen_soft_reset !== 1'b0 || o_gen_valid !== 1'b1)
      $display("FAIL start_ignored_busy: got seed %h soft %b valid %b want 3c 0 1",
               o_gen_seed, o_gen_soft_reset, o_gen_valid);
    else n_pass++;
    wait_done(40, n, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || !seen || o_period !== e.period)
      $display("FAIL busy_run_result: got done %b period %0d want 1 %0d", seen, o_period, e.period);
    else n_pass++;
    tick();
    i_stop = 1'b1;
    start(8'h44, 16'd5);
    i_stop = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_gen_soft_reset !== 1'b0 || o_gen_seed !== 8'h3C)
      $display("FAIL stop_beats_start: got busy %b soft %b seed %h want 0 0 3c",
               o_busy, o_gen_soft_reset, o_gen_seed);
    else n_pass++;
    exp_q.push_back(mk_exp(8'h44, 4, 1'b0));
    start(8'h44, 16'd5);
    wait_run(ok);
    v0 = vcnt;
    wait_done(40, n, seen);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || !seen || (vcnt - v0) != 5 || o_gen_seed !== 8'h44 || o_period !== e.period)
      $display("FAIL back_to_back: got done %b steps %0d seed %h period %0d want 1 5 44 %0d",
               seen, vcnt - v0, o_gen_seed, o_period, e.period);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_period();
    test_seed_zero();
    test_burst_pause();
    test_stop();
    test_reset_mid_run();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
